// File: rtl/mesh_term_tx_pkg.sv
// Shared definitions for the mesh terminal transmitter slice.
//   - Default mesh geometry and queue depth.
//   - Packet field offsets/widths for the default packet size.
//   - mesh_pkt_t: packed packet layout {next-jump, dest, mode, payload}.
//   - BCAST: broadcast address that replaces {row,col}.
//   - dest_field(): selects the destination byte for a host request.
package mesh_term_tx_pkg;

  localparam int unsigned ROWS_DEF       = 4;
  localparam int unsigned COLUMS_DEF     = 4;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned PCKG_SZ   = 40;
  localparam int unsigned NXT_MSB   = PCKG_SZ - 1;
  localparam int unsigned DST_MSB   = PCKG_SZ - 9;
  localparam int unsigned MODE_BIT  = PCKG_SZ - 17;
  localparam int unsigned PAYLOAD_W = PCKG_SZ - 17;
  localparam int unsigned SEQ_W     = 8;

  localparam logic [7:0] BCAST = 8'hFF;

  typedef struct packed {
    logic [7:0]           nxt;      // next-jump, filled in by the router
    logic [7:0]           dst;      // {row,col} or broadcast address
    logic                 mode;     // 0 row-first, 1 column-first
    logic [PAYLOAD_W-1:0] payload;
  } mesh_pkt_t;

  function automatic logic [7:0] dest_field(input logic       bcast,
                                            input logic [3:0] row,
                                            input logic [3:0] col,
                                            input logic [7:0] bc_addr);
    return bcast ? bc_addr : {row, col};
  endfunction

endpackage

// File: rtl/mesh_term_tx_if.sv
// Host/mesh bundle for one terminal transmitter.
//   master: host + router side (drives wr_* requests and popin, observes status/head)
//   slave : transmitter side (drives full/count/pndng_i_in/data_out_i_in/err_*)
//   wr_en, wr_row[3:0], wr_col[3:0], wr_bcast, wr_mode, wr_payload[pckg_sz-18:0] : push request
//   full, count, pndng_i_in, data_out_i_in[pckg_sz-1:0], popin                   : queue/mesh side
//   err_ovf, err_udf                                                              : sticky errors
interface mesh_term_tx_if
  import mesh_term_tx_pkg::*;
#(
  parameter int unsigned pckg_sz    = PCKG_SZ,
  parameter int unsigned fifo_depth = FIFO_DEPTH_DEF
);
  localparam int unsigned CountW = $clog2(fifo_depth + 1);

  logic               wr_en;
  logic [3:0]         wr_row;
  logic [3:0]         wr_col;
  logic               wr_bcast;
  logic               wr_mode;
  logic [pckg_sz-18:0] wr_payload;
  logic               full;
  logic [CountW-1:0]  count;
  logic               pndng_i_in;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               popin;
  logic               err_ovf;
  logic               err_udf;

  modport master (
    output wr_en, wr_row, wr_col, wr_bcast, wr_mode, wr_payload, popin,
    input  full, count, pndng_i_in, data_out_i_in, err_ovf, err_udf
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_bcast, wr_mode, wr_payload, popin,
    output full, count, pndng_i_in, data_out_i_in, err_ovf, err_udf
  );

endinterface

// File: rtl/mesh_term_tx_fifo.sv
// Generic circular-buffer queue of Depth entries (any Depth >= 2).
//   clk, reset : clock, asynchronous active-high reset (clears pointers and count)
//   push/wdata : enqueue; honoured when not full, or when full and popping this cycle
//   pop        : dequeue head; ignored while empty
//   head       : current head entry, 0 while empty
//   count/full/empty : decodes of registered occupancy only
module mesh_term_tx_fifo #(
  parameter  int unsigned Width  = 8,
  parameter  int unsigned Depth  = 4,
  localparam int unsigned CountW = $clog2(Depth + 1),
  localparam int unsigned PtrW   = $clog2(Depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [Width-1:0]  wdata,
  output logic [Width-1:0]  head,
  output logic [CountW-1:0] count,
  output logic              full,
  output logic              empty
);

  logic [Width-1:0]  mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CountW'(Depth));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop & ~empty;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal-side transmitter for one mesh port.
// Builds a packet from a host push request, queues it, and offers the head to the router.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset; discards all queued packets
//   bus   : mesh_term_tx_if.slave (host push request, router pop, status, sticky errors)
// Optional feature: define MESH_TX_SEQ_EN to stamp the low 8 payload bits with an 8-bit
// sequence number that advances on every accepted push (dropped pushes do not advance it).
module mesh_term_tx
  import mesh_term_tx_pkg::*;
#(
  parameter int unsigned ROWS       = ROWS_DEF,
  parameter int unsigned COLUMS     = COLUMS_DEF,
  parameter int unsigned pckg_sz    = PCKG_SZ,
  parameter int unsigned fifo_depth = FIFO_DEPTH_DEF,
  parameter logic [7:0]  bdcst      = BCAST
) (
  input logic          clk,
  input logic          reset,
  mesh_term_tx_if.slave bus
);

  localparam int unsigned CountW = $clog2(fifo_depth + 1);

  mesh_pkt_t         wr_pkt;
  mesh_pkt_t         head_pkt;
  logic [CountW-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

`ifdef MESH_TX_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             push_acc;

  assign push_acc = bus.wr_en & (~fifo_full | bus.popin);
  assign seq_d    = push_acc ? seq_q + SEQ_W'(1) : seq_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end
`endif

  always_comb begin
    wr_pkt         = '0;
    wr_pkt.nxt     = 8'h00;
    wr_pkt.dst     = dest_field(bus.wr_bcast, bus.wr_row, bus.wr_col, bdcst);
    wr_pkt.mode    = bus.wr_mode;
    wr_pkt.payload = bus.wr_payload;
`ifdef MESH_TX_SEQ_EN
    wr_pkt.payload[SEQ_W-1:0] = seq_q;
`endif
  end

  mesh_term_tx_fifo #(
    .Width ($bits(mesh_pkt_t)),
    .Depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (bus.popin),
    .wdata (wr_pkt),
    .head  (head_pkt),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Overflow only when nothing leaves to make room; underflow on any pop of an empty queue.
  always_comb begin
    err_ovf_d = err_ovf_q | (bus.wr_en & fifo_full & ~bus.popin);
    err_udf_d = err_udf_q | (bus.popin & fifo_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign bus.full          = fifo_full;
  assign bus.count         = fifo_count;
  assign bus.pndng_i_in    = ~fifo_empty;
  assign bus.data_out_i_in = head_pkt;
  assign bus.err_ovf       = err_ovf_q;
  assign bus.err_udf       = err_udf_q;

  // Out-of-mesh destinations are still queued; this only flags them in simulation.
  dest_range_a: assert property (@(posedge clk) disable iff (reset)
      (bus.wr_en && !bus.wr_bcast) |->
      (32'(bus.wr_row) < ROWS && 32'(bus.wr_col) < COLUMS))
    else $warning("mesh_term_tx: destination outside mesh");

endmodule

// File: tb/tb_mesh_term_tx.sv
module tb_mesh_term_tx;
  import mesh_term_tx_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_term_tx_if #(.pckg_sz(PCKG_SZ), .fifo_depth(DEPTH)) bus ();

  mesh_term_tx #(
    .ROWS       (4),
    .COLUMS     (4),
    .pckg_sz    (PCKG_SZ),
    .fifo_depth (DEPTH),
    .bdcst      (BCAST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue contents in order plus visible-state snapshot for the monitor.
  logic [PCKG_SZ-1:0] sb_q[$];
  int mcount = 0;
  bit m_ovf = 0, m_udf = 0;
  int seq = 0;
  int cur_count = 0;
  bit cur_ovf = 0, cur_udf = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [PCKG_SZ-1:0] make_pkt(input bit bc, input int row, input int col,
                                                 input bit mode,
                                                 input logic [PAYLOAD_W-1:0] pl);
    logic [PCKG_SZ-1:0] p;
    logic [PAYLOAD_W-1:0] body;
    int dst;
    dst  = bc ? 255 : row * 16 + col;
    body = pl;
`ifdef MESH_TX_SEQ_EN
    body = (pl & ~PAYLOAD_W'(255)) | PAYLOAD_W'(seq);
`endif
    p = '0;
    p = p | (PCKG_SZ'(dst) << (DST_MSB - 7));
    p = p | (PCKG_SZ'(mode) << MODE_BIT);
    p = p | PCKG_SZ'(body);
    return p;
  endfunction

  // One clock cycle of stimulus; called at posedge+1, returns at the following posedge+1.
  task automatic step(input bit en, input int row, input int col, input bit bc, input bit mode,
                      input logic [PAYLOAD_W-1:0] pl, input bit pop);
    bit push_ok, pop_ok;
    cur_count = mcount;
    cur_ovf   = m_ovf;
    cur_udf   = m_udf;
    bus.wr_en      = en;
    bus.wr_row     = 4'(row);
    bus.wr_col     = 4'(col);
    bus.wr_bcast   = bc;
    bus.wr_mode    = mode;
    bus.wr_payload = pl;
    bus.popin      = pop;
    pop_ok  = pop && (mcount > 0);
    push_ok = en && ((mcount < int'(DEPTH)) || pop);
    if (push_ok) begin
      sb_q.push_back(make_pkt(bc, row, col, mode, pl));
      seq = (seq + 1) % 256;
    end
    if (en && mcount == int'(DEPTH) && !pop) m_ovf = 1;
    if (pop && mcount == 0) m_udf = 1;
    mcount = mcount + int'(push_ok) - int'(pop_ok);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic model_clear();
    sb_q.delete();
    mcount = 0;
    m_ovf = 0;
    m_udf = 0;
    seq = 0;
    cur_count = 0;
    cur_ovf = 0;
    cur_udf = 0;
  endtask

  // Asserts reset between edges, checks the immediate effect, releases away from an edge.
  task automatic do_reset(input string tag);
    mon_en = 0;
    bus.wr_en = 0;
    bus.popin = 0;
    #2;
    reset = 1'b1;
    #1;
    chk({tag, "_pndng_async"}, 64'(bus.pndng_i_in), 64'(0));
    chk({tag, "_count_async"}, 64'(bus.count), 64'(0));
    chk({tag, "_data_async"}, 64'(bus.data_out_i_in), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    mon_en = 1;
  endtask

  // Monitor: compares visible state and pops the scoreboard on each router dequeue.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count", 64'(bus.count), 64'(cur_count));
      chk("full", 64'(bus.full), 64'(cur_count == int'(DEPTH)));
      chk("pndng", 64'(bus.pndng_i_in), 64'(cur_count != 0));
      chk("err_ovf", 64'(bus.err_ovf), 64'(cur_ovf));
      chk("err_udf", 64'(bus.err_udf), 64'(cur_udf));
      if (cur_count == 0) begin
        chk("data_empty", 64'(bus.data_out_i_in), 64'(0));
      end else if (sb_q.size() == 0) begin
        chk("scoreboard_underrun", 64'(0), 64'(1));
      end else begin
        chk("head", 64'(bus.data_out_i_in), 64'(sb_q[0]));
        chk("nxt_jump", 64'(bus.data_out_i_in[NXT_MSB -: 8]), 64'(0));
        if (bus.popin) void'(sb_q.pop_front());
      end
    end
  end

  logic [PCKG_SZ-1:0] t1_exp;

  initial begin
    reset          = 1'b1;
    bus.wr_en      = 0;
    bus.wr_row     = '0;
    bus.wr_col     = '0;
    bus.wr_bcast   = 0;
    bus.wr_mode    = 0;
    bus.wr_payload = '0;
    bus.popin      = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    mon_en = 1;
    idle(1);

    // Single push: 1-cycle latency, exact packet layout.
`ifdef MESH_TX_SEQ_EN
    t1_exp = 40'h00_21_0_00100;
`else
    t1_exp = 40'h00_21_0_00155;
`endif
    step(1, 2, 1, 0, 0, PAYLOAD_W'(23'h155), 0);
    chk("t1_data", 64'(bus.data_out_i_in), 64'(t1_exp));
    chk("t1_count", 64'(bus.count), 64'(1));
    chk("t1_pndng", 64'(bus.pndng_i_in), 64'(1));
    step(0, 0, 0, 0, 0, '0, 1);
    chk("t1_drained", 64'(bus.data_out_i_in), 64'(0));

    // Fill, then push+pop while full: no drop, order preserved.
    for (int i = 0; i < 4; i++) step(1, i, 3 - i, 0, i[0], PAYLOAD_W'(i * 7 + 1), 0);
    chk("t3_full", 64'(bus.full), 64'(1));
    step(1, 3, 3, 0, 1, PAYLOAD_W'(23'h7abcd), 1);
    chk("t3_count", 64'(bus.count), 64'(4));
    chk("t3_ovf", 64'(bus.err_ovf), 64'(0));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, '0, 1);
    chk("t3_empty", 64'(bus.count), 64'(0));

    // Five pushes into four entries: last dropped, head untouched.
    for (int i = 0; i < 5; i++) step(1, 1 + (i % 3), 2, 0, 0, PAYLOAD_W'(100 + i), 0);
    chk("t2_full", 64'(bus.full), 64'(1));
    chk("t2_count", 64'(bus.count), 64'(4));
    chk("t2_ovf", 64'(bus.err_ovf), 64'(1));
    chk("t2_head_dst", 64'(bus.data_out_i_in[DST_MSB -: 8]), 64'(8'h12));
    idle(2);

    // Underflow and broadcast, including push+pop on an empty queue.
    do_reset("t4");
    step(0, 0, 0, 0, 0, '0, 1);
    chk("t4_udf", 64'(bus.err_udf), 64'(1));
    chk("t4_count", 64'(bus.count), 64'(0));
    chk("t4_data", 64'(bus.data_out_i_in), 64'(0));
    step(1, 0, 0, 1, 1, PAYLOAD_W'(5), 1);
    chk("t4_count_push", 64'(bus.count), 64'(1));
    chk("t4_bcast_dst", 64'(bus.data_out_i_in[DST_MSB -: 8]), 64'(8'hFF));
    chk("t4_mode", 64'(bus.data_out_i_in[MODE_BIT]), 64'(1));
    step(0, 0, 0, 0, 0, '0, 1);

    // Reset mid-operation with three queued.
    for (int i = 0; i < 3; i++) step(1, i, i, 0, 0, PAYLOAD_W'(i + 9), 0);
    chk("t5_count_before", 64'(bus.count), 64'(3));
    do_reset("t5");
    idle(1);
    chk("t5_count_after", 64'(bus.count), 64'(0));

    // Randomized traffic with varying pressure.
    for (int i = 0; i < 800; i++) begin
      int pop_pct;
      pop_pct = (i < 300) ? 25 : ((i < 550) ? 75 : 50);
      step(($urandom % 100) < 60, $urandom_range(0, 3), $urandom_range(0, 3),
           ($urandom % 8) == 0, $urandom % 2, PAYLOAD_W'($urandom),
           ($urandom % 100) < pop_pct);
    end
    idle(2);

`ifdef MESH_TX_SEQ_EN
    // 257 push/pop pairs: sequence wraps 0xFF -> 0x00.
    do_reset("t6");
    for (int i = 0; i < 257; i++) begin
      step(1, 1, 1, 0, 0, PAYLOAD_W'(23'h7fff00), 0);
      if (i == 256) chk("t6_wrap", 64'(bus.data_out_i_in[7:0]), 64'(0));
      if (i == 255) chk("t6_last", 64'(bus.data_out_i_in[7:0]), 64'(8'hFF));
      step(0, 0, 0, 0, 0, '0, 1);
    end
`endif

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
